sand_cmd_queue: RTL and testbench

SAND_CMD_QUEUE -- requirements
Module: sand_cmd_queue

---
 rtl/sand_cmd_queue.sv | 124 ++++++++++++
 tb/tb_sand_cmd_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sand_cmd_queue.sv
// Command queue between the HPS Avalon-MM slave and the sand engine: four staging registers,
// a show-ahead FIFO of committed commands, a status register and a sticky overflow flag.
module sand_cmd_queue #(
  parameter int unsigned COORD_W = 8,
  parameter int unsigned TYPE_W  = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               chipselect,
  input  logic               write,
  input  logic               read,
  input  logic [2:0]         address,
  input  logic [7:0]         writedata,
  output logic [7:0]         readdata,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [COORD_W-1:0] cmd_x,
  output logic [COORD_W-1:0] cmd_y,
  output logic [COORD_W-1:0] cmd_radius,
  output logic [TYPE_W-1:0]  cmd_type,
  output logic               overflow
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = 3 * COORD_W + TYPE_W;

  logic [COORD_W-1:0] stage_x_q, stage_y_q, stage_radius_q;
  logic [TYPE_W-1:0]  stage_type_q;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic               overflow_q;
  logic [7:0]         readdata_q;
  logic [EntryW-1:0]  mem_q [DEPTH];
  logic [EntryW-1:0]  head;

  logic bus_wr, bus_rd, commit, clear_ovf, full, empty, pop, push, drop;

  assign bus_wr    = chipselect && write;
  assign bus_rd    = chipselect && read;
  assign commit    = bus_wr && (address == 3'd4);
  assign clear_ovf = bus_wr && (address == 3'd5);
  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign pop       = !empty && cmd_ready;
  // A pop in the same cycle frees the slot, so a commit into a full FIFO still lands.
  assign push      = commit && (!full || pop);
  assign drop      = commit && full && !pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage_x_q      <= '0;
      stage_y_q      <= '0;
      stage_radius_q <= '0;
      stage_type_q   <= '0;
    end else if (bus_wr) begin
      unique case (address)
        3'd0:    stage_x_q      <= writedata[COORD_W-1:0];
        3'd1:    stage_y_q      <= writedata[COORD_W-1:0];
        3'd2:    stage_radius_q <= writedata[COORD_W-1:0];
        3'd3:    stage_type_q   <= writedata[TYPE_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clear_ovf) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Storage carries no reset; the outputs are masked while the queue is empty instead.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {stage_x_q, stage_y_q, stage_radius_q, stage_type_q};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata_q <= 8'h00;
    end else if (bus_rd) begin
      unique case (address)
        3'd0:    readdata_q <= 8'(stage_x_q);
        3'd1:    readdata_q <= 8'(stage_y_q);
        3'd2:    readdata_q <= 8'(stage_radius_q);
        3'd3:    readdata_q <= 8'(stage_type_q);
        3'd5:    readdata_q <= {overflow_q, full, empty, 5'(count_q)};
        default: readdata_q <= 8'h00;
      endcase
    end
  end

  assign head       = empty ? '0 : mem_q[rd_ptr_q];
  assign cmd_valid  = !empty;
  assign cmd_x      = head[EntryW-1 -: COORD_W];
  assign cmd_y      = head[EntryW-1-COORD_W -: COORD_W];
  assign cmd_radius = head[TYPE_W +: COORD_W];
  assign cmd_type   = head[TYPE_W-1:0];
  assign overflow   = overflow_q;
  assign readdata   = readdata_q;

endmodule

// File: tb/tb_sand_cmd_queue.sv
// Directed bench for sand_cmd_queue: a queue-based model checked every cycle, plus
// hand-computed literal expectations for the documented scenarios.
module tb_sand_cmd_queue;

  localparam int unsigned Depth = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       chipselect, write, read, cmd_ready;
  logic [2:0] address;
  logic [7:0] writedata, readdata;
  logic       cmd_valid, overflow;
  logic [7:0] cmd_x, cmd_y, cmd_radius;
  logic [1:0] cmd_type;

  sand_cmd_queue #(.COORD_W(8), .TYPE_W(2), .DEPTH(Depth)) dut (
    .clock      (clock),
    .reset      (reset),
    .chipselect (chipselect),
    .write      (write),
    .read       (read),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_radius (cmd_radius),
    .cmd_type   (cmd_type),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] x, y, r;
    logic [1:0] t;
  } cmd_t;

  cmd_t       m_q[$];
  cmd_t       m_stage;
  logic       m_ovf;
  logic [7:0] m_rd;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_stage = '{x: 8'h0, y: 8'h0, r: 8'h0, t: 2'h0};
    m_ovf   = 1'b0;
    m_rd    = 8'h00;
  endtask

  // Applies the bus and handshake inputs present at this rising edge to the model.
  task automatic model_step();
    int   size = m_q.size();
    logic pop  = (size != 0) && cmd_ready;
    cmd_t pushed = m_stage;
    if (chipselect && read) begin
      case (address)
        3'd0: m_rd = m_stage.x;
        3'd1: m_rd = m_stage.y;
        3'd2: m_rd = m_stage.r;
        3'd3: m_rd = {6'b0, m_stage.t};
        3'd5: m_rd = {m_ovf, size == Depth, size == 0, 5'(size)};
        default: m_rd = 8'h00;
      endcase
    end
    if (pop) void'(m_q.pop_front());
    if (chipselect && write) begin
      case (address)
        3'd0: m_stage.x = writedata;
        3'd1: m_stage.y = writedata;
        3'd2: m_stage.r = writedata;
        3'd3: m_stage.t = writedata[1:0];
        3'd4: if (size < Depth || pop) m_q.push_back(pushed); else m_ovf = 1'b1;
        3'd5: m_ovf = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic commit_x(input logic [7:0] x);
    bus_write(3'd0, x);
    bus_write(3'd4, 8'h00);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("cmd_valid", cmd_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("cmd_x", cmd_x, m_q[0].x);
        chk("cmd_y", cmd_y, m_q[0].y);
        chk("cmd_radius", cmd_radius, m_q[0].r);
        chk("cmd_type", cmd_type, m_q[0].t);
      end
      chk("overflow", overflow, m_ovf);
      chk("readdata", readdata, m_rd);
    end
  end

  initial begin
    logic [7:0] rd;
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 3'd0; writedata = 8'h00; cmd_ready = 1'b0;
    model_reset();
    #22 reset = 1'b0;
    chk("reset_valid", cmd_valid, 1'b0);
    chk("reset_fields", {cmd_x, cmd_y, cmd_radius, cmd_type}, 0);

    // Single command, show-ahead one cycle after commit.
    bus_write(3'd0, 8'h10);
    bus_write(3'd1, 8'h20);
    bus_write(3'd2, 8'h03);
    bus_write(3'd3, 8'h01);
    bus_write(3'd4, 8'h00);
    chk("first_valid", cmd_valid, 1'b1);
    chk("first_fields", {cmd_x, cmd_y, cmd_radius, cmd_type}, {8'h10, 8'h20, 8'h03, 2'h1});
    bus_read(3'd5, rd);
    chk("status_one", rd, 8'h01);
    cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;

    // Fill past capacity, then drain in order.
    for (int i = 0; i < 9; i++) commit_x(8'(i));
    bus_read(3'd5, rd);
    chk("status_full_ovf", rd, 8'hC8);
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_x", cmd_x, i);
      tick();
    end
    cmd_ready = 1'b0;
    chk("drained_valid", cmd_valid, 1'b0);
    bus_read(3'd5, rd);
    chk("status_drained", rd, 8'hA0);

    // Commit with a simultaneous pop while full.
    bus_write(3'd5, 8'h00);
    for (int i = 0; i < 8; i++) commit_x(8'(i));
    bus_write(3'd0, 8'h55);
    cmd_ready = 1'b1;
    bus_write(3'd4, 8'h00);
    cmd_ready = 1'b0;
    bus_read(3'd5, rd);
    chk("status_commit_pop", rd, 8'h48);
    chk("no_overflow", overflow, 1'b0);
    cmd_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk("drain2_x", cmd_x, i);
      tick();
    end
    chk("last_x", cmd_x, 8'h55);
    tick();
    cmd_ready = 1'b0;
    chk("drained2_valid", cmd_valid, 1'b0);

    // Field truncation, overflow set and cleared, writes to unused addresses.
    bus_write(3'd3, 8'hFF);
    bus_read(3'd3, rd);
    chk("type_trunc", rd, 8'h03);
    bus_write(3'd6, 8'hAA);
    bus_write(3'd7, 8'hAA);
    bus_read(3'd6, rd);
    chk("addr6_read", rd, 8'h00);
    for (int i = 0; i < 9; i++) commit_x(8'(8'h80 + i));
    bus_read(3'd5, rd);
    chk("status_ovf_set", rd[7], 1'b1);
    bus_write(3'd5, 8'h00);
    bus_read(3'd5, rd);
    chk("status_ovf_clr", rd, 8'h48);

    // Leave three commands queued with overflow set, then reset mid-cycle.
    bus_write(3'd4, 8'h00);
    cmd_ready = 1'b1;
    repeat (5) tick();
    cmd_ready = 1'b0;
    bus_read(3'd5, rd);
    chk("status_three", rd, 8'h83);
    #3 reset = 1'b1;
    model_reset();
    #1;
    chk("async_valid", cmd_valid, 1'b0);
    chk("async_overflow", overflow, 1'b0);
    chk("async_readdata", readdata, 8'h00);
    chk("async_fields", {cmd_x, cmd_y, cmd_radius, cmd_type}, 0);
    #8 reset = 1'b0;
    bus_read(3'd5, rd);
    chk("status_after_reset", rd, 8'h20);
    bus_read(3'd0, rd);
    chk("stage_after_reset", rd, 8'h00);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
